// File: rtl/c5_mult_issue_pkg.sv
// ---------------------------------------------------------------------------
// c5_mult_issue_pkg
//   Shared constants for the issue/interlock stage in front of the c5_mult
//   multiply/divide unit:
//     - MULT_* function codes understood by c5_mult
//     - ZERO word constant
//     - issue FSM state encoding and the busy-cycle count
//     - small op-class decode helpers
// ---------------------------------------------------------------------------
package c5_mult_issue_pkg;

  localparam logic [3:0]  MULT_NOTHING       = 4'b0000;
  localparam logic [3:0]  MULT_READ_LO       = 4'b0001;
  localparam logic [3:0]  MULT_READ_HI       = 4'b0010;
  localparam logic [3:0]  MULT_WRITE_LO      = 4'b0011;
  localparam logic [3:0]  MULT_WRITE_HI      = 4'b0100;
  localparam logic [3:0]  MULT_MULT          = 4'b0101;
  localparam logic [3:0]  MULT_SIGNED_MULT   = 4'b0110;
  localparam logic [3:0]  MULT_DIVIDE        = 4'b0111;
  localparam logic [3:0]  MULT_SIGNED_DIVIDE = 4'b1000;

  localparam logic [31:0] ZERO = 32'h0000_0000;

  // Accept-to-idle distance of the unit's 32-step sequencer.
  localparam int C5_MULT_BUSY_CYCLES = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_READ = 2'b10,
    ST_RESP = 2'b11
  } state_t;

  function automatic logic is_read(input logic [3:0] func);
    return (func == MULT_READ_LO) || (func == MULT_READ_HI);
  endfunction

  function automatic logic is_write(input logic [3:0] func);
    return (func == MULT_WRITE_LO) || (func == MULT_WRITE_HI);
  endfunction

  // Functions that start the 32-step sequencer.
  function automatic logic is_mult_div(input logic [3:0] func);
    return (func == MULT_MULT) || (func == MULT_SIGNED_MULT) ||
           (func == MULT_DIVIDE) || (func == MULT_SIGNED_DIVIDE);
  endfunction

endpackage

// File: rtl/c5_mult_issue.sv
// ---------------------------------------------------------------------------
// c5_mult_issue
//   Issue/interlock stage directly upstream of c5_mult. HI/LO requests arrive
//   over a valid/ready handshake and are re-driven to the unit as registered
//   operands and a one-cycle function pulse. While a multiply/divide runs,
//   new writes and operations are held off so the running operation is never
//   clobbered. MFHI/MFLO results return over a valid/ready response channel.
//
//   Ports:
//     I_clk, I_rst_n            clock, asynchronous active-low reset
//     I_req_valid/O_req_ready   request handshake
//     I_req_op, I_rs, I_rt      MULT_* code and operands
//     O_a, O_b, O_mult_func     registered drive into c5_mult
//     I_c_mult, I_pause         result and stall from c5_mult
//     O_rsp_valid/I_rsp_ready   response handshake, O_rsp_data payload
//     O_busy                    sequencer counter nonzero
//
//   Build option: C5_MULT_ISSUE_READ_OVERLAP_EN
//     When defined, READ_LO/READ_HI are accepted while BUSY and the unit's
//     I_pause provides the stall; after the response the FSM returns to BUSY
//     if the counter is still running.
// ---------------------------------------------------------------------------
module c5_mult_issue
  import c5_mult_issue_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int BUSY_CYCLES = C5_MULT_BUSY_CYCLES
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_req_valid,
  output logic             O_req_ready,
  input  logic [3:0]       I_req_op,
  input  logic [WIDTH-1:0] I_rs,
  input  logic [WIDTH-1:0] I_rt,
  output logic [WIDTH-1:0] O_a,
  output logic [WIDTH-1:0] O_b,
  output logic [3:0]       O_mult_func,
  input  logic [WIDTH-1:0] I_c_mult,
  input  logic             I_pause,
  output logic             O_rsp_valid,
  output logic [WIDTH-1:0] O_rsp_data,
  input  logic             I_rsp_ready,
  output logic             O_busy
);

  localparam int CNT_W = $clog2(BUSY_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_CYCLES);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       func_q, func_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic             req_ready_s;
  logic             accept_s;
  logic [CNT_W-1:0] cnt_dec_s;

  // Request-ready decode from the current state.
  always_comb begin
    req_ready_s = 1'b0;
    case (state_q)
      ST_IDLE: req_ready_s = 1'b1;
`ifdef C5_MULT_ISSUE_READ_OVERLAP_EN
      // Only reads may overlap a running operation; the unit stalls them.
      ST_BUSY: req_ready_s = is_read(I_req_op);
`else
      ST_BUSY: req_ready_s = 1'b0;
`endif
      ST_READ: req_ready_s = 1'b0;
      ST_RESP: req_ready_s = 1'b0;
      default: req_ready_s = 1'b0;
    endcase
  end

  assign accept_s = I_req_valid & req_ready_s;

  // Free-running down-count, independent of state so it keeps time across READ/RESP.
  always_comb begin
    if (cnt_q != CNT_ZERO) begin
      cnt_dec_s = cnt_q - CNT_ONE;
    end else begin
      cnt_dec_s = CNT_ZERO;
    end
  end

  // Next-state, issue and response logic for the interlock FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_dec_s;
    a_d         = a_q;
    b_d         = b_q;
    func_d      = MULT_NOTHING;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      ST_IDLE, ST_BUSY: begin
        if (accept_s && is_write(I_req_op)) begin
          a_d    = I_rs;
          b_d    = I_rt;
          func_d = I_req_op;
        end else if (accept_s && is_mult_div(I_req_op)) begin
          a_d     = I_rs;
          b_d     = I_rt;
          func_d  = I_req_op;
          cnt_d   = CNT_LOAD;
          state_d = ST_BUSY;
        end else if (accept_s && is_read(I_req_op)) begin
          func_d  = I_req_op;
          state_d = ST_READ;
        end else if ((state_q == ST_BUSY) && (cnt_dec_s == CNT_ZERO)) begin
          // Ready rises in the very cycle the counter reads zero.
          state_d = ST_IDLE;
        end else begin
          // NOTHING and codes 1001-1111 are accepted and dropped.
          state_d = state_q;
        end
      end
      ST_READ: begin
        if (!I_pause) begin
          rsp_data_d  = I_c_mult;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          // Keep presenting the read code until the unit releases the stall.
          func_d = func_q;
        end
      end
      ST_RESP: begin
        if (I_rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef C5_MULT_ISSUE_READ_OVERLAP_EN
          if (cnt_dec_s != CNT_ZERO) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
`else
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the mult unit shares this reset net.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      func_q      <= MULT_NOTHING;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      func_q      <= func_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign O_req_ready = req_ready_s;
  assign O_a         = a_q;
  assign O_b         = b_q;
  assign O_mult_func = func_q;
  assign O_rsp_valid = rsp_valid_q;
  assign O_rsp_data  = rsp_data_q;
  assign O_busy      = (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_c5_mult_issue.sv
// ---------------------------------------------------------------------------
// tb_c5_mult_issue
//   Directed bench for c5_mult_issue with a behavioural stand-in for the
//   c5_mult unit (HI/LO registers, 32-step counter, pause on early reads).
//   Expected read results are pushed into a queue when a read is issued; a
//   negedge monitor pops and compares each accepted response.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_c5_mult_issue;
  import c5_mult_issue_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = MULT_NOTHING;
  logic [W-1:0] rs = 32'h0;
  logic [W-1:0] rt = 32'h0;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   mult_func;
  logic [W-1:0] c_mult;
  logic         pause;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_ready = 1'b1;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb[$];

  always #5 clk = ~clk;

  c5_mult_issue dut (
    .I_clk       (clk),
    .I_rst_n     (rst_n),
    .I_req_valid (req_valid),
    .O_req_ready (req_ready),
    .I_req_op    (req_op),
    .I_rs        (rs),
    .I_rt        (rt),
    .O_a         (a),
    .O_b         (b),
    .O_mult_func (mult_func),
    .I_c_mult    (c_mult),
    .I_pause     (pause),
    .O_rsp_valid (rsp_valid),
    .O_rsp_data  (rsp_data),
    .I_rsp_ready (rsp_ready),
    .O_busy      (busy)
  );

  // ---------------- c5_mult stand-in ----------------
  logic [W-1:0] hi_r, lo_r;
  logic [5:0]   ucnt_r;
  logic signed [63:0] sa_s, sb_s, smul_s;
  logic [63:0]        umul_s;

  assign sa_s   = {{32{a[31]}}, a};
  assign sb_s   = {{32{b[31]}}, b};
  assign smul_s = sa_s * sb_s;
  assign umul_s = {32'h0, a} * {32'h0, b};
  assign pause  = (ucnt_r != 6'd0) && ((mult_func == MULT_READ_LO) || (mult_func == MULT_READ_HI));
  assign c_mult = (mult_func == MULT_READ_HI) ? hi_r : lo_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= 32'h0; lo_r <= 32'h0; ucnt_r <= 6'd0;
    end else begin
      if (ucnt_r != 6'd0) ucnt_r <= ucnt_r - 6'd1;
      case (mult_func)
        MULT_WRITE_LO: lo_r <= a;
        MULT_WRITE_HI: hi_r <= a;
        MULT_MULT:        begin {hi_r, lo_r} <= umul_s; ucnt_r <= 6'd32; end
        MULT_SIGNED_MULT: begin {hi_r, lo_r} <= smul_s; ucnt_r <= 6'd32; end
        MULT_DIVIDE: begin
          if (b != 32'h0) begin lo_r <= a / b; hi_r <= a % b; end
          ucnt_r <= 6'd32;
        end
        MULT_SIGNED_DIVIDE: begin
          if (b != 32'h0) begin lo_r <= $signed(a) / $signed(b); hi_r <= $signed(a) % $signed(b); end
          ucnt_r <= 6'd32;
        end
        default: ;
      endcase
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got 0x%08h, no response expected", rsp_data);
      end else begin
        logic [W-1:0] exp;
        exp = sb.pop_front();
        if (rsp_data !== exp) begin
          errors++;
          $display("FAIL rsp_data: got 0x%08h, expected 0x%08h", rsp_data, exp);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] rs_v, input logic [W-1:0] rt_v,
                       output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    req_valid = 1'b1; req_op = op; rs = rs_v; rt = rt_v;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1; else waited++;
      @(posedge clk); #1;
    end
    req_valid = 1'b0; req_op = MULT_NOTHING;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: op %b not accepted within 200 cycles", op);
    end
  endtask

  // Wait for the queue to drain; returns just after the consuming posedge.
  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic read(input logic [3:0] op, input logic [W-1:0] exp, output int waited);
    sb.push_back(exp);
    issue(op, 32'h0, 32'h0, waited);
    drain();
  endtask

  // Counts cycles with ready low (starting at the next negedge), then realigns after a posedge.
  task automatic wait_ready(output int lows);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) break;
      lows++;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a", a, 32'h0);
    chk("rst_b", b, 32'h0);
    chk("rst_func", {28'h0, mult_func}, {28'h0, MULT_NOTHING});
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // MULT 7*6: issue timing and 33-cycle interlock.
    issue(MULT_MULT, 32'd7, 32'd6, w);
    @(negedge clk);
    chk("mult_func_pulse", {28'h0, mult_func}, {28'h0, MULT_MULT});
    chk("mult_a", a, 32'd7);
    chk("mult_b", b, 32'd6);
    chk("mult_busy", {31'h0, busy}, 32'h1);
    n = req_ready ? 0 : 1;
    @(negedge clk);
    chk("mult_func_one_cycle", {28'h0, mult_func}, {28'h0, MULT_NOTHING});
    if (!req_ready) n++;
    for (int i = 0; i < 100 && !req_ready; i++) begin
      @(negedge clk);
      if (!req_ready) n++;
    end
    chk("mult_ready_low_cycles", n, 32'd33);
    chk("mult_busy_done", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    read(MULT_READ_LO, 32'd42, w);
    chk("read_lo_no_wait", w, 32'd0);
    read(MULT_READ_HI, 32'd0, w);

    // SIGNED_MULT -3*5.
    issue(MULT_SIGNED_MULT, 32'hFFFF_FFFD, 32'd5, w);
    wait_ready(n);
    chk("smult_ready_low_cycles", n, 32'd33);
    read(MULT_READ_LO, 32'hFFFF_FFF1, w);
    read(MULT_READ_HI, 32'hFFFF_FFFF, w);

    // DIVIDE 100/7 and SIGNED_DIVIDE -100/7.
    issue(MULT_DIVIDE, 32'd100, 32'd7, w);
    wait_ready(n);
    read(MULT_READ_LO, 32'd14, w);
    read(MULT_READ_HI, 32'd2, w);
    issue(MULT_SIGNED_DIVIDE, 32'hFFFF_FF9C, 32'd7, w);
    wait_ready(n);
    read(MULT_READ_LO, 32'hFFFF_FFF2, w);

    // Back-to-back writes.
    req_valid = 1'b1; req_op = MULT_WRITE_HI; rs = 32'h1234_5678; rt = 32'h0;
    @(negedge clk);
    chk("wr_hi_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    req_op = MULT_WRITE_LO; rs = 32'h9ABC_DEF0;
    @(negedge clk);
    chk("wr_lo_ready", {31'h0, req_ready}, 32'h1);
    chk("wr_hi_func", {28'h0, mult_func}, {28'h0, MULT_WRITE_HI});
    chk("wr_hi_a", a, 32'h1234_5678);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = MULT_NOTHING;
    @(negedge clk);
    chk("wr_lo_func", {28'h0, mult_func}, {28'h0, MULT_WRITE_LO});
    chk("wr_lo_a", a, 32'h9ABC_DEF0);
    chk("wr_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("wr_func_idle", {28'h0, mult_func}, {28'h0, MULT_NOTHING});
    @(posedge clk); #1;
    read(MULT_READ_HI, 32'h1234_5678, w);

    // Response back-pressure: hold for 5 cycles.
    rsp_ready = 1'b0;
    sb.push_back(32'h9ABC_DEF0);
    issue(MULT_READ_LO, 32'h0, 32'h0, w);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk("stall_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_data", rsp_data, 32'h9ABC_DEF0);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Reserved code 1010 is accepted and ignored.
    issue(4'b1010, 32'hDEAD_BEEF, 32'h0BAD_F00D, w);
    @(negedge clk);
    chk("rsvd_func", {28'h0, mult_func}, {28'h0, MULT_NOTHING});
    chk("rsvd_ready", {31'h0, req_ready}, 32'h1);
    chk("rsvd_busy", {31'h0, busy}, 32'h0);
    chk("rsvd_a_kept", a, 32'h9ABC_DEF0);
    @(posedge clk); #1;

    // Read issued two cycles after MULT 7*6.
    issue(MULT_MULT, 32'd7, 32'd6, w);
    @(posedge clk); #1;
    read(MULT_READ_LO, 32'd42, w);
`ifdef C5_MULT_ISSUE_READ_OVERLAP_EN
    chk("overlap_read_wait", w, 32'd0);
`else
    chk("busy_read_wait", w, 32'd32);
`endif
    for (int i = 0; i < 100 && busy; i++) @(posedge clk);
    #1;
    wait_ready(n);
    read(MULT_READ_HI, 32'd0, w);

    // Reset in the middle of an operation (counter = 10).
    issue(MULT_MULT, 32'd5, 32'd5, w);
    repeat (23) @(posedge clk);
    #2;
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_a", a, 32'h0);
    chk("mid_rst_b", b, 32'h0);
    chk("mid_rst_func", {28'h0, mult_func}, {28'h0, MULT_NOTHING});
    chk("mid_rst_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(MULT_MULT, 32'd3, 32'd3, w);
    wait_ready(n);
    read(MULT_READ_LO, 32'd9, w);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c5_mult_issue.md
Name: c5_mult_issue

Overview:
- Issue/interlock stage directly upstream of the multiply/divide unit (c5_mult).
- Accepts HI/LO requests from the decode stage over a valid/ready handshake, then drives the unit's operand and function inputs with registered outputs.
- Blocks new writes and operations while a 32-step multiply or divide is in progress, so a running operation is never clobbered.
- Returns MFHI/MFLO results over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width.
- BUSY_CYCLES, 33, cycles from accepting a mult/div request until the unit's step counter is idle.

Ports:
- I_clk  in  1  clock
- I_rst_n  in  1  reset; asynchronous, active-low
- I_req_valid  in  1  request valid
- O_req_ready  out  1  request accepted when valid&&ready at posedge
- I_req_op  in  4  MULT_* function code
- I_rs  in  WIDTH  operand A (rs)
- I_rt  in  WIDTH  operand B (rt)
- O_a  out  WIDTH  registered operand A to mult unit
- O_b  out  WIDTH  registered operand B to mult unit
- O_mult_func  out  4  registered function code to mult unit
- I_c_mult  in  WIDTH  result from mult unit
- I_pause  in  1  mult unit pause (read while busy)
- O_rsp_valid  out  1  read result valid
- O_rsp_data  out  WIDTH  read result
- I_rsp_ready  in  1  response consumer ready
- O_busy  out  1  mult/div step counter nonzero

Behaviour:
- Reset state:
  - Asynchronous, active-low.
  - State IDLE; O_a = O_b = 0; O_mult_func = MULT_NOTHING; O_rsp_valid = 0; O_rsp_data = 0; counter = 0.
  - Reset mid-operation abandons everything. The mult unit shares the reset net.
- States: IDLE, BUSY, READ, RESP.
- Default output: O_mult_func = MULT_NOTHING every cycle unless stated otherwise.
- Registered issue:
  - A request accepted at edge t appears on O_a, O_b and O_mult_func during cycle t+1.
  - Writes and mult/div functions are held for exactly one cycle.
- IDLE:
  - O_req_ready = 1.
  - On accept of MULT_NOTHING: ignored.
  - On accept of WRITE_LO/WRITE_HI: issue the function; stay IDLE. Back-to-back writes are allowed.
  - On accept of MULT, SIGNED_MULT, DIVIDE or SIGNED_DIVIDE: issue the function; load counter = BUSY_CYCLES; go to BUSY.
  - On accept of READ_LO/READ_HI: go to READ.
- BUSY:
  - O_req_ready = 0.
  - Counter decrements by 1 per cycle.
  - In the cycle the counter equals 0: state = IDLE and O_req_ready = 1.
  - A request accepted in that cycle issues at t+35 relative to the original accept.
- READ:
  - O_mult_func holds the READ code.
  - On the first cycle with I_pause = 0: capture I_c_mult into O_rsp_data; set O_rsp_valid; go to RESP.
  - Stay in READ while I_pause = 1.
- RESP:
  - O_mult_func = MULT_NOTHING.
  - O_rsp_valid and O_rsp_data are held stable until I_rsp_ready; then clear valid and go to IDLE (IDLE is entered the following cycle).
  - O_req_ready = 0, so only one read is outstanding.
- O_busy = (counter != 0). The counter keeps running across READ/RESP.
- Codes 1001–1111 are treated as MULT_NOTHING.

Optional Feature:
- Macro: C5_MULT_ISSUE_READ_OVERLAP_EN.
- Defined:
  - In BUSY, O_req_ready = 1 for READ_LO/READ_HI only, and O_req_ready is computed from I_req_op.
  - An accepted read goes to READ with the counter still decrementing; the mult unit's I_pause provides the stall.
  - Writes and operations in BUSY still see ready = 0.
  - After RESP, return to BUSY if counter != 0, else IDLE.
- Undefined: O_req_ready = 0 throughout BUSY; no dependence of ready on I_req_op.

Decomposition:
- Shared package c5_parameters.v holds the MULT_* codes: NOTHING 0000, READ_LO 0001, READ_HI 0010, WRITE_LO 0011, WRITE_HI 0100, MULT 0101, SIGNED_MULT 0110, DIVIDE 0111, SIGNED_DIVIDE 1000. It also holds ZERO.
- New package constants: the state encodings and C5_MULT_BUSY_CYCLES = 33.
- Sub-module: none. The counter is inline; the bench instantiates c5_mult alongside.

Test Plan:
- MULT rs=7 rt=6, then READ_LO, then READ_HI -> ready low for 33 cycles; responses 42 and 0.
- SIGNED_MULT rs=0xFFFFFFFD rt=5, then READ_LO/READ_HI -> 0xFFFFFFF1 and 0xFFFFFFFF.
- DIVIDE rs=100 rt=7, then READ_LO/READ_HI -> 14 and 2. SIGNED_DIVIDE rs=-100 rt=7, then READ_LO -> 0xFFFFFFF2.
- WRITE_HI 0x12345678, WRITE_LO 0x9ABCDEF0 back to back, then READ_HI -> ready stays 1 for both writes; O_mult_func pulses 0100 then 0011; response 0x12345678.
- READ_LO with I_rsp_ready low for 5 cycles -> O_rsp_valid and O_rsp_data stable for 5 cycles; O_req_ready = 0 throughout.
- Reset asserted at counter=10 -> outputs zeroed asynchronously; after release, MULT 3*3 -> READ_LO 9.
- With C5_MULT_ISSUE_READ_OVERLAP_EN: READ_LO issued 2 cycles after MULT 7*6 -> accepted; response 42 arrives once I_pause falls.
